// File: rtl/encryptor_pkg.sv
// Shared types and constants for the receive-side block packer.
package encryptor_pkg;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        HOLD
    } packer_state_t;

    localparam int DEFAULT_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_BYTES     = 16;

endpackage

// File: rtl/block_pad_mask.sv
// Combinational pad helper: slots at or beyond count take the pad byte.
module block_pad_mask
    import encryptor_pkg::*;
#(
    parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
    parameter int LEN_W       = $clog2(BLOCK_BYTES + 1)
) (
    input  logic [LEN_W-1:0]         count,
    input  logic [7:0]               pad_byte,
    output logic [BLOCK_BYTES-1:0]   slot_en,
    output logic [8*BLOCK_BYTES-1:0] pad_data
);

    // Slot 0 sits in the top byte of the block.
    always_comb begin
        slot_en  = '0;
        pad_data = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            slot_en[i]                          = (LEN_W'(i) >= count);
            pad_data[8*(BLOCK_BYTES-1-i) +: 8]  = pad_byte;
        end
    end

endmodule

// File: rtl/block_packer.sv
// Byte-to-block packer: pops a FWFT byte FIFO, assembles MSB-first blocks, pads on flush.
// Define PACKER_PKCS7_PAD_EN for PKCS#7 padding (including full pad block on empty flush).
module block_packer
    import encryptor_pkg::*;
#(
    parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
    parameter int LEN_W       = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     fifo_empty,
    input  logic [7:0]               fifo_data,
    output logic                     fifo_pop,
    input  logic                     flush,
    output logic                     block_valid,
    input  logic                     block_ready,
    output logic [8*BLOCK_BYTES-1:0] block_data,
    output logic [LEN_W-1:0]         block_len,
    output logic                     busy
);

    packer_state_t            state, state_next;
    logic [LEN_W-1:0]         count, count_next;
    logic                     flush_pend, flush_pend_next;
    logic [8*BLOCK_BYTES-1:0] data_q, data_next;
    logic                     pop;
    logic [7:0]               pad_byte;
    logic [BLOCK_BYTES-1:0]   slot_en;
    logic [8*BLOCK_BYTES-1:0] pad_data;

`ifdef PACKER_PKCS7_PAD_EN
    localparam bit PAD_EMPTY = 1'b1;
    assign pad_byte = 8'(BLOCK_BYTES) - 8'(count);
`else
    localparam bit PAD_EMPTY = 1'b0;
    assign pad_byte = 8'h00;
`endif

    block_pad_mask #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .LEN_W       (LEN_W)
    ) u_pad_mask (
        .count    (count),
        .pad_byte (pad_byte),
        .slot_en  (slot_en),
        .pad_data (pad_data)
    );

    // A new flush pulse always wins over the clear on PAD entry, so it is never lost.
    always_comb begin
        state_next      = state;
        count_next      = count;
        flush_pend_next = flush_pend | flush;
        data_next       = data_q;
        pop             = 1'b0;
        block_valid     = 1'b0;
        case (state)
            FILL: begin
                pop = !fifo_empty;
                if (pop) begin
                    for (int i = 0; i < BLOCK_BYTES; i++) begin
                        if (count == LEN_W'(i)) begin
                            data_next[8*(BLOCK_BYTES-1-i) +: 8] = fifo_data;
                        end
                    end
                    count_next = count + 1'b1;
                    if (count_next == LEN_W'(BLOCK_BYTES)) begin
                        state_next = HOLD;
                    end
                end else if (flush_pend) begin
                    flush_pend_next = flush;
                    if (count != '0 || PAD_EMPTY) begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < BLOCK_BYTES; i++) begin
                    if (slot_en[i]) begin
                        data_next[8*(BLOCK_BYTES-1-i) +: 8] = pad_data[8*(BLOCK_BYTES-1-i) +: 8];
                    end
                end
                state_next = HOLD;
            end
            HOLD: begin
                block_valid = 1'b1;
                if (block_ready) begin
                    count_next = '0;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= FILL;
            count      <= '0;
            flush_pend <= 1'b0;
            data_q     <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            flush_pend <= flush_pend_next;
            data_q     <= data_next;
        end
    end

    // Gate the pop with reset so a non-empty FIFO is never drained while held in reset.
    assign fifo_pop   = pop & n_rst;
    assign block_data = data_q;
    assign block_len  = count;
    assign busy       = (count != '0) || flush_pend || (state != FILL);

endmodule

// File: tb/tb_block_packer.sv
// Directed self-checking bench for block_packer (16-byte and 8-byte instances).
module tb_block_packer;

`ifdef PACKER_PKCS7_PAD_EN
    localparam bit PKCS = 1'b1;
`else
    localparam bit PKCS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_rst;
    logic         flush, block_ready, flush8, ready8;
    logic         fifo_empty, fifo_pop, block_valid, busy;
    logic [7:0]   fifo_data;
    logic [127:0] block_data;
    logic [4:0]   block_len;
    logic         fifo_empty8, fifo_pop8, block_valid8, busy8;
    logic [7:0]   fifo_data8;
    logic [63:0]  block_data8;
    logic [3:0]   block_len8;

    logic [7:0]   mem [256];
    logic [7:0]   wr_ptr = 8'd0;
    logic [7:0]   rd_ptr = 8'd0;
    logic [7:0]   mem8 [256];
    logic [7:0]   wr_ptr8 = 8'd0;
    logic [7:0]   rd_ptr8 = 8'd0;

    int           total = 0;
    int           bad = 0;
    int           wait_cycles = 0;
    int           hs_count = 0;
    int           base;
    logic [127:0] last_data = '0;
    logic [4:0]   last_len = '0;
    logic [7:0]   pad;

    always #5 clk = ~clk;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_data   = mem[rd_ptr];
    assign fifo_empty8 = (wr_ptr8 == rd_ptr8);
    assign fifo_data8  = mem8[rd_ptr8];

    always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
    always @(posedge clk) if (fifo_pop8) rd_ptr8 <= rd_ptr8 + 8'd1;

    always @(posedge clk) begin
        if (block_valid && block_ready) begin
            hs_count  <= hs_count + 1;
            last_data <= block_data;
            last_len  <= block_len;
        end
    end

    block_packer #(.BLOCK_BYTES(16)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_pop    (fifo_pop),
        .flush       (flush),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .block_len   (block_len),
        .busy        (busy)
    );

    block_packer #(.BLOCK_BYTES(8)) dut8 (
        .clk         (clk),
        .n_rst       (n_rst),
        .fifo_empty  (fifo_empty8),
        .fifo_data   (fifo_data8),
        .fifo_pop    (fifo_pop8),
        .flush       (flush8),
        .block_valid (block_valid8),
        .block_ready (ready8),
        .block_data  (block_data8),
        .block_len   (block_len8),
        .busy        (busy8)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = first + 8'(i);
            wr_ptr      = wr_ptr + 8'd1;
        end
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (!block_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!block_valid) checkOutput("validTimeout", 128'(block_valid), 128'd1);
        wait_cycles = n;
    endtask

    initial begin
        n_rst = 1'b0;
        flush = 1'b0;
        block_ready = 1'b1;
        flush8 = 1'b0;
        ready8 = 1'b1;

        // Bytes are already queued while reset is held: nothing may be popped.
        applyStimulus(8'h00, 16);
        @(negedge clk);
        checkOutput("rstPop", 128'(fifo_pop), 128'd0);
        checkOutput("rstValid", 128'(block_valid), 128'd0);
        checkOutput("rstData", block_data, 128'd0);
        checkOutput("rstLen", 128'(block_len), 128'd0);
        checkOutput("rstBusy", 128'(busy), 128'd0);
        n_rst = 1'b1;

        repeat (15) @(negedge clk);
        checkOutput("earlyValid", 128'(block_valid), 128'd0);
        @(negedge clk);
        checkOutput("fullValid", 128'(block_valid), 128'd1);
        checkOutput("fullData", block_data, 128'h000102030405060708090A0B0C0D0E0F);
        checkOutput("fullLen", 128'(block_len), 128'd16);
        @(negedge clk);
        checkOutput("idleValid", 128'(block_valid), 128'd0);
        checkOutput("idleBusy", 128'(busy), 128'd0);

        // Short packet followed by a flush.
        applyStimulus(8'hA0, 5);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        waitValid(20);
        checkOutput("flushLat", 128'(wait_cycles), 128'd6);
        pad = PKCS ? 8'h0B : 8'h00;
        checkOutput("shortData", block_data, {40'hA0A1A2A3A4, {11{pad}}});
        checkOutput("shortLen", 128'(block_len), 128'd5);
        @(negedge clk);

        // Backpressure with four extra bytes waiting behind the block.
        block_ready = 1'b0;
        applyStimulus(8'hB0, 16);
        applyStimulus(8'hC0, 4);
        waitValid(40);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bpPop", 128'(fifo_pop), 128'd0);
            checkOutput("bpData", block_data, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
        end
        block_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpRelValid", 128'(block_valid), 128'd0);
        checkOutput("bpResume", 128'(fifo_pop), 128'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        waitValid(20);
        pad = PKCS ? 8'h0C : 8'h00;
        checkOutput("tailData", block_data, {32'hC0C1C2C3, {12{pad}}});
        checkOutput("tailLen", 128'(block_len), 128'd4);
        @(negedge clk);

        // Flush arriving in the same cycle as the 16th pop.
        base = hs_count;
        applyStimulus(8'h10, 16);
        repeat (15) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("coinValid", 128'(block_valid), 128'd1);
        checkOutput("coinLen", 128'(block_len), 128'd16);
        checkOutput("coinData", block_data, 128'h101112131415161718191A1B1C1D1E1F);
        repeat (8) @(negedge clk);
        checkOutput("coinBlocks", 128'(hs_count - base), PKCS ? 128'd2 : 128'd1);
        checkOutput("coinLastLen", 128'(last_len), PKCS ? 128'd0 : 128'd16);
        checkOutput("coinLastData", last_data,
                    PKCS ? {16{8'h10}} : 128'h101112131415161718191A1B1C1D1E1F);
        checkOutput("coinBusy", 128'(busy), 128'd0);

        // Asynchronous reset in the middle of a block.
        applyStimulus(8'h50, 7);
        repeat (7) @(negedge clk);
        checkOutput("preRstBusy", 128'(busy), 128'd1);
        n_rst = 1'b0;
        #1;
        checkOutput("midRstPop", 128'(fifo_pop), 128'd0);
        checkOutput("midRstValid", 128'(block_valid), 128'd0);
        checkOutput("midRstData", block_data, 128'd0);
        checkOutput("midRstLen", 128'(block_len), 128'd0);
        checkOutput("midRstBusy", 128'(busy), 128'd0);
        @(negedge clk);
        n_rst = 1'b1;
        applyStimulus(8'h60, 16);
        waitValid(40);
        checkOutput("postRstData", block_data, 128'h606162636465666768696A6B6C6D6E6F);
        checkOutput("postRstLen", 128'(block_len), 128'd16);
        @(negedge clk);

        // 8-byte instance: three bytes then flush.
        for (int i = 0; i < 3; i++) begin
            mem8[wr_ptr8] = 8'(i + 1);
            wr_ptr8       = wr_ptr8 + 8'd1;
        end
        flush8 = 1'b1;
        @(negedge clk);
        flush8 = 1'b0;
        begin
            int n = 0;
            while (!block_valid8 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("bb8Valid", 128'(block_valid8), 128'd1);
        checkOutput("bb8Len", 128'(block_len8), 128'd3);
        pad = PKCS ? 8'h05 : 8'h00;
        checkOutput("bb8Data", 128'(block_data8), 128'({24'h010203, {5{pad}}}));
        @(negedge clk);
        checkOutput("bb8Busy", 128'(busy8), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
